// File: rtl/bist_pkg.sv
// Shared types and constants for the BIST response end: FSM states, the
// all-ones seed shared with the LFSR pattern generator, and the default tap mask.
package bist_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    COMPARE = 2'd2,
    DONE    = 2'd3
  } bist_state_t;

  // Wide enough for any practical signature; users take the low SIG_W bits.
  localparam logic [63:0] SIG_SEED = '1;
  localparam logic [7:0]  POLY_DEF = 8'hB8;

endpackage

// File: rtl/bist_misr.sv
// Multiple-input signature register: shift left, feed back the XOR of the tapped
// bits into bit 0, and fold the response into the low IN_W bits.
module bist_misr
  import bist_pkg::*;
#(
  parameter int               IN_W  = 3,
  parameter int               SIG_W = 8,
  parameter logic [SIG_W-1:0] POLY  = SIG_W'(POLY_DEF)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             en,
  input  logic [IN_W-1:0]  resp_data,
  output logic [SIG_W-1:0] sig
);

  logic             fb;
  logic [SIG_W-1:0] sig_next;

  always_comb begin
    fb       = ^(sig & POLY);
    sig_next = {sig[SIG_W-2:0], fb} ^ SIG_W'(resp_data);
  end

  always_ff @(posedge clk) begin
    if (reset || load) sig <= SIG_SEED[SIG_W-1:0];
    else if (en)       sig <= sig_next;
  end

endmodule

// File: rtl/bist_misr_checker.sv
// BIST output response analyzer: compresses PATTERN_COUNT responses into a MISR
// and compares against GOLDEN_SIG. Define BIST_SIG_READOUT_EN to expose live sig.
module bist_misr_checker
  import bist_pkg::*;
#(
  parameter int               IN_W          = 3,
  parameter int               SIG_W         = 8,
  parameter logic [SIG_W-1:0] POLY          = SIG_W'(POLY_DEF),
  parameter int               PATTERN_COUNT = 63,
  parameter logic [SIG_W-1:0] GOLDEN_SIG    = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             resp_valid,
  input  logic [IN_W-1:0]  resp_data,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [SIG_W-1:0] signature
);

  localparam int CNT_W = $clog2(PATTERN_COUNT + 1);

  bist_state_t      state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [SIG_W-1:0] sig;
  logic             load, accept, last;

  // start is only honoured from the resting states; RUN/COMPARE ignore it
  assign load   = start && (state_q == IDLE || state_q == DONE);
  assign accept = (state_q == RUN) && resp_valid;
  assign last   = accept && (cnt_q == CNT_W'(PATTERN_COUNT - 1));

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE, DONE: if (start) state_d = RUN;
      RUN:        if (last)  state_d = COMPARE;
      COMPARE:               state_d = DONE;
      default:               state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == RUN) || (state_q == COMPARE);
  end

  always_ff @(posedge clk) begin
    if (reset || load) cnt_q <= '0;
    else if (accept)   cnt_q <= cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset || load) begin
      done <= 1'b0;
      pass <= 1'b0;
    end else if (state_q == COMPARE) begin
      done <= 1'b1;
      pass <= (sig == GOLDEN_SIG);
    end
  end

  bist_misr #(
    .IN_W  (IN_W),
    .SIG_W (SIG_W),
    .POLY  (POLY)
  ) u_misr (
    .clk       (clk),
    .reset     (reset),
    .load      (load),
    .en        (accept),
    .resp_data (resp_data),
    .sig       (sig)
  );

`ifdef BIST_SIG_READOUT_EN
  assign signature = sig;
`else
  assign signature = '0;
`endif

endmodule

// File: tb/tb_bist_misr_checker.sv
// Scoreboard bench: two checkers (1-sample and 4-sample runs); expected results are
// queued when the last sample is driven and popped when done rises.
module tb_bist_misr_checker;

  localparam logic [7:0] G1 = 8'hFE;
  localparam logic [7:0] G4 = 8'hD6;  // signature of GSEQ from the all-ones seed
  localparam logic [3:0][2:0] GSEQ = {3'b001, 3'b010, 3'b000, 3'b100};
  localparam logic [3:0][2:0] OSEQ = {3'b110, 3'b101, 3'b011, 3'b111};

  typedef struct {
    logic       pass;
    logic [7:0] sig;
    int         cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic st1, rv1, st4, rv4;
  logic [2:0] rd1, rd4;
  logic busy1, done1, pass1, busy4, done4, pass4;
  logic [7:0] sig1, sig4;
  int cyc = 0;
  int n_chk = 0;
  int n_err = 0;
  exp_t q1[$];
  exp_t q4[$];
  logic pd1 = 1'b0;
  logic pd4 = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  bist_misr_checker #(.PATTERN_COUNT(1), .GOLDEN_SIG(G1)) dut1 (
    .clk(clk), .reset(rst), .start(st1), .resp_valid(rv1), .resp_data(rd1),
    .busy(busy1), .done(done1), .pass(pass1), .signature(sig1));

  bist_misr_checker #(.PATTERN_COUNT(4), .GOLDEN_SIG(G4)) dut4 (
    .clk(clk), .reset(rst), .start(st4), .resp_valid(rv4), .resp_data(rd4),
    .busy(busy4), .done(done4), .pass(pass4), .signature(sig4));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] mstep(input logic [7:0] s, input logic [2:0] d);
    logic fb;
    fb = s[7] ^ s[5] ^ s[4] ^ s[3];
    return {s[6:0], fb} ^ {5'b0, d};
  endfunction

  // Expected signature port value: live sig with readout, zeros otherwise
  function automatic logic [7:0] sexp(input logic [7:0] s);
`ifdef BIST_SIG_READOUT_EN
    return s;
`else
    return (s & 8'h00);
`endif
  endfunction

  function automatic logic busy_of(input bit w);
    return w ? busy4 : busy1;
  endfunction
  function automatic logic done_of(input bit w);
    return w ? done4 : done1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit w, input logic s, input logic v, input logic [2:0] d);
    if (w) begin st4 = s; rv4 = v; rd4 = d; end
    else   begin st1 = s; rv1 = v; rd1 = d; end
  endtask

  // poke: pulse start mid-RUN before sample 2; clash: resp_valid alongside start
  task automatic do_run(input bit w, input logic [3:0][2:0] d, input logic [3:0][3:0] gap,
                        input int n, input bit poke, input bit clash);
    logic [7:0] m;
    exp_t e;
    m = 8'hFF;
    drive(w, 1'b1, clash, 3'b111);
    tick();
    drive(w, 1'b0, 1'b0, 3'b000);
    chk(w ? "busy4_start" : "busy1_start", busy_of(w), 1'b1);
    chk(w ? "done4_drop" : "done1_drop", done_of(w), 1'b0);
    for (int i = 0; i < n; i++) begin
      for (int j = 0; j < int'(gap[i]); j++) begin
        drive(w, poke && i == 2 && j == 0, 1'b0, 3'b000);
        tick();
      end
      drive(w, 1'b0, 1'b1, d[i]);
      m = mstep(m, d[i]);
      if (i == n - 1) begin
        e.pass = (m == (w ? G4 : G1));
        e.sig  = m;
        e.cyc  = cyc + 2;
        if (w) q4.push_back(e);
        else   q1.push_back(e);
      end
      tick();
      drive(w, 1'b0, 1'b0, 3'b000);
    end
    for (int k = 0; k < 6 && (w ? q4.size() : q1.size()) != 0; k++) tick();
    chk(w ? "done4_seen" : "done1_seen", (w ? q4.size() : q1.size()) == 0, 1'b1);
    if (w) q4.delete();
    else   q1.delete();
  endtask

  always @(negedge clk) begin
    exp_t e;
    pd1 <= done1;
    pd4 <= done4;
    if (done1 && !pd1) begin
      if (q1.size() == 0) chk("done1_unexpected", 1'b1, 1'b0);
      else begin
        e = q1.pop_front();
        chk("pass1", pass1, e.pass);
        chk("lat1", cyc, e.cyc);
        chk("sig1_end", sig1, sexp(e.sig));
      end
    end
    if (done4 && !pd4) begin
      if (q4.size() == 0) chk("done4_unexpected", 1'b1, 1'b0);
      else begin
        e = q4.pop_front();
        chk("pass4", pass4, e.pass);
        chk("lat4", cyc, e.cyc);
        chk("sig4_end", sig4, sexp(e.sig));
      end
    end
  end

  initial begin
    rst = 1'b1;
    drive(0, 0, 0, 0);
    drive(1, 0, 0, 0);
    repeat (3) tick();
    rst = 1'b0;
    chk("rst_busy1", busy1, 1'b0);
    chk("rst_done1", done1, 1'b0);
    chk("rst_pass1", pass1, 1'b0);
    chk("rst_busy4", busy4, 1'b0);
    chk("rst_done4", done4, 1'b0);
    chk("rst_sig4", sig4, sexp(8'hFF));

    // resp_valid in IDLE is ignored
    drive(1, 0, 1, 3'b111);
    tick();
    drive(1, 0, 0, 0);
    chk("idle_rv_busy", busy4, 1'b0);
    chk("idle_rv_done", done4, 1'b0);
    chk("idle_rv_sig", sig4, sexp(8'hFF));

    // single-sample runs
    do_run(0, {3'd0, 3'd0, 3'd0, 3'b000}, '0, 1, 0, 0);
    chk("pc1_zero_pass", pass1, 1'b1);
    chk("pc1_zero_sig", sig1, sexp(8'hFE));
    do_run(0, {3'd0, 3'd0, 3'd0, 3'b101}, '0, 1, 0, 0);
    chk("pc1_101_pass", pass1, 1'b0);
    chk("pc1_101_done", done1, 1'b1);
    chk("pc1_101_sig", sig1, sexp(8'hFB));

    // four samples with gaps 0, 2, 5 between them
    do_run(1, GSEQ, {4'd5, 4'd2, 4'd0, 4'd0}, 4, 0, 0);
    chk("gseq_pass", pass4, 1'b1);

    // resp_valid in DONE is ignored
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 1, 3'b010);
      tick();
    end
    drive(1, 0, 0, 0);
    chk("done_rv_done", done4, 1'b1);
    chk("done_rv_pass", pass4, 1'b1);
    chk("done_rv_busy", busy4, 1'b0);
    chk("done_rv_sig", sig4, sexp(G4));

    // back-to-back: failing run then a passing one
    do_run(1, OSEQ, {4'd0, 4'd1, 4'd0, 4'd0}, 4, 0, 0);
    do_run(1, GSEQ, {4'd0, 4'd0, 4'd0, 4'd0}, 4, 0, 0);
    chk("b2b_pass", pass4, 1'b1);

    // start during RUN, and start+resp_valid together in IDLE/DONE
    do_run(1, GSEQ, {4'd0, 4'd3, 4'd1, 4'd1}, 4, 1, 0);
    do_run(1, GSEQ, {4'd0, 4'd0, 4'd0, 4'd0}, 4, 0, 1);

    // reset after two samples aborts the run
    drive(1, 1, 0, 0);
    tick();
    drive(1, 0, 1, GSEQ[0]);
    tick();
    drive(1, 0, 1, GSEQ[1]);
    tick();
    drive(1, 0, 0, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_busy", busy4, 1'b0);
    chk("abort_done", done4, 1'b0);
    chk("abort_pass", pass4, 1'b0);
    chk("abort_sig", sig4, sexp(8'hFF));
    repeat (4) tick();
    chk("abort_no_done", done4, 1'b0);
    do_run(1, GSEQ, {4'd2, 4'd0, 4'd1, 4'd0}, 4, 0, 0);
    chk("after_abort_pass", pass4, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
